ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register.
- Consumes the registered control signals and decoded operands, then computes the ALU result and NZCV flags.
- Captures the result into an internal EX/MEM pipeline register with a valid/stall/flush handshake.
- Keeps the architectural flag register and a saturating stall counter.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 4, register index width (R0-R15).
- CNT_WIDTH, 16, stall counter width.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- valid_in  input  1  ID/EX holds a real instruction
- reg_write_enable_in  input  1  register write enable
- mem_write_enable_in  input  1  memory write enable
- mem_to_reg_select_in  input  1  writeback from memory
- alu_src_select_in  input  1  0: operand B = rm_data_in; 1: operand B = imm_in
- alu_control_in  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- set_flags_in  input  1  update NZCV
- rn_data_in  input  DATA_WIDTH  operand A
- rm_data_in  input  DATA_WIDTH  operand B / store data
- imm_in  input  DATA_WIDTH  immediate
- rn_addr_in, rm_addr_in  input  REG_ADDR_WIDTH  source indices (used by forwarding)
- rd_addr_in  input  REG_ADDR_WIDTH  destination index
- stall_in  input  1  MEM stage cannot accept
- flush_in  input  1  kill the instruction being captured
- ready_out  output  1  equals !stall_in || flush_in
- valid_out  output  1  EX/MEM slot holds a real instruction
- reg_write_enable_out, mem_write_enable_out, mem_to_reg_select_out  output  1 each  registered controls
- alu_result_out  output  DATA_WIDTH  registered result
- store_data_out  output  DATA_WIDTH  registered rm_data (post-forwarding)
- rd_addr_out  output  REG_ADDR_WIDTH  registered destination
- flags_out  output  4  NZCV register, bit3 = N
- stall_count_out  output  CNT_WIDTH  saturating stall-cycle count

Behaviour:
- Reset: every output register is 0, including valid_out, flags_out and stall_count_out.
- Latency: 1 cycle from ID/EX inputs to EX/MEM outputs. The combinational ALU feeds the output register.
- Operand B is imm_in when alu_src_select_in = 1, else rm_data_in.
- ADD/SUB:
  - Width is DATA_WIDTH+1 internally. SUB is A + ~B + 1.
  - C = carry out; for SUB, C = 1 means no borrow.
  - V = signed overflow of the operands.
- AND/ORR: C and V keep their previous values; only N and Z update.
- N = result MSB; Z = (result == 0).
- Priority per cycle is flush_in > stall_in > normal.
- Flush:
  - valid_out, reg_write_enable_out and mem_write_enable_out are 0 next cycle.
  - Data fields are don't-care; drive them to 0.
  - Flags are not updated.
- Stall (no flush):
  - All EX/MEM outputs and flags hold.
  - The incoming instruction is not consumed; upstream holds it.
- Normal: capture. valid_out = valid_in. Control outputs are ANDed with valid_in, so a bubble never writes.
- Flags update only on a capture with valid_in && set_flags_in. Flushed or stalled instructions never change flags.
- stall_count_out increments on stall_in && valid_in && !flush_in. It saturates at all-ones and does not wrap.
- A reset asserted mid-stall clears state; the held instruction is lost.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined:
  - Forwarding hit: valid_out && reg_write_enable_out && !mem_to_reg_select_out && rd_addr_out == rn_addr_in, with address != 15. Operand A then uses alu_result_out.
  - Same rule for rm_addr_in, which replaces both operand B (when alu_src_select_in = 0) and store data.
  - Forwarding is evaluated against the current EX/MEM contents, including during a stall.
- Undefined: operands are used as supplied, and the address inputs are unused.

Decomposition:
- Shared package (pipeline pkg):
  - ALU op encodings ALU_ADD/SUB/AND/ORR.
  - NZCV bit index constants.
  - Default widths.
- One natural sub-module: ex_alu, combinational. Inputs are A, B, op and old C/V; outputs are result and NZCV.
- ex_stage owns muxing, the pipeline register, flags and the counter.

Test Plan:
- Reset then idle: all outputs 0.
- ADD 0x7FFFFFFF + 1 with set_flags: next cycle result 0x80000000, flags 1001 (N,V).
- SUB 5 - 5 with set_flags: result 0, flags 0110 (Z,C).
- SUB 3 - 5 with set_flags: result 0xFFFFFFFE, flags 1000.
- AND with imm (alu_src = 1) 0xF0F0 & 0x0FF0 after a carry-setting op: result 0x00F0, C retained.
- Stall 3 cycles with valid_in = 1:
  - Outputs frozen.
  - stall_count_out = 3.
  - Release: the held instruction is captured once, with no duplicate.
- Flush together with stall, instruction ADD, reg_write = 1:
  - Next cycle valid_out = 0 and reg_write_enable_out = 0.
  - flags_out unchanged.
- EX_FWD_EN: ADD r1 = 2 + 3, then back-to-back ADD r2 = r1 + 1 with stale rn_data = 0. Second result is 6.
  - Repeat with rd = 15: result is 1, no forwarding.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared ALU op encodings, NZCV bit positions and default widths for the execute stage
package ex_stage_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int REG_ADDR_WIDTH_DEF = 4;
   localparam int CNT_WIDTH_DEF      = 16;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU producing the result and NZCV flags
// Logical ops pass the previous C and V straight through.
module ex_alu
   import ex_stage_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  alu_op_e               op_in,
   input  logic                  c_in,
   input  logic                  v_in,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic [3:0]            nzcv_out
);

   logic                  is_sub;
   logic [DATA_WIDTH-1:0] b_eff;
   logic [DATA_WIDTH:0]   sum;
   logic                  c_next;
   logic                  v_next;

   always_comb begin
      is_sub = (op_in == ALU_SUB);
      b_eff  = is_sub ? ~b_in : b_in;
      // SUB is A + ~B + 1, so carry out means "no borrow"
      sum    = {1'b0, a_in} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, is_sub};

      result_out = '0;
      c_next     = c_in;
      v_next     = v_in;
      case (op_in)
         ALU_ADD, ALU_SUB: begin
            result_out = sum[DATA_WIDTH-1:0];
            c_next     = sum[DATA_WIDTH];
            v_next     = (a_in[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                         (sum[DATA_WIDTH-1] != a_in[DATA_WIDTH-1]);
         end
         ALU_AND: result_out = a_in & b_in;
         ALU_ORR: result_out = a_in | b_in;
         default: result_out = '0;
      endcase

      nzcv_out         = '0;
      nzcv_out[FLAG_N] = result_out[DATA_WIDTH-1];
      nzcv_out[FLAG_Z] = (result_out == '0);
      nzcv_out[FLAG_C] = c_next;
      nzcv_out[FLAG_V] = v_next;
   end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand select, ALU, EX/MEM register, NZCV flags, stall counter
// Operand forwarding from the EX/MEM register is built only when EX_FWD_EN is defined.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      valid_in,
   input  logic                      reg_write_enable_in,
   input  logic                      mem_write_enable_in,
   input  logic                      mem_to_reg_select_in,
   input  logic                      alu_src_select_in,
   input  logic [1:0]                alu_control_in,
   input  logic                      set_flags_in,
   input  logic [DATA_WIDTH-1:0]     rn_data_in,
   input  logic [DATA_WIDTH-1:0]     rm_data_in,
   input  logic [DATA_WIDTH-1:0]     imm_in,
   input  logic [REG_ADDR_WIDTH-1:0] rn_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0] rm_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
   input  logic                      stall_in,
   input  logic                      flush_in,
   output logic                      ready_out,
   output logic                      valid_out,
   output logic                      reg_write_enable_out,
   output logic                      mem_write_enable_out,
   output logic                      mem_to_reg_select_out,
   output logic [DATA_WIDTH-1:0]     alu_result_out,
   output logic [DATA_WIDTH-1:0]     store_data_out,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
   output logic [3:0]                flags_out,
   output logic [CNT_WIDTH-1:0]      stall_count_out
);

   logic                      valid_q, valid_d;
   logic                      rwe_q, rwe_d;
   logic                      mwe_q, mwe_d;
   logic                      mtr_q, mtr_d;
   logic [DATA_WIDTH-1:0]     result_q, result_d;
   logic [DATA_WIDTH-1:0]     store_q, store_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
   logic [3:0]                flags_q, flags_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0]     op_a;
   logic [DATA_WIDTH-1:0]     rm_val;
   logic [DATA_WIDTH-1:0]     op_b;
   logic [DATA_WIDTH-1:0]     alu_result;
   logic [3:0]                alu_nzcv;

`ifdef EX_FWD_EN
   // R15 is never forwarded; its value is supplied by the register read
   localparam logic [REG_ADDR_WIDTH-1:0] NO_FWD_ADDR = REG_ADDR_WIDTH'(15);

   logic fwd_ok;
   logic fwd_a;
   logic fwd_b;

   always_comb begin
      fwd_ok = valid_q && rwe_q && !mtr_q;
      fwd_a  = fwd_ok && (rd_q == rn_addr_in) && (rn_addr_in != NO_FWD_ADDR);
      fwd_b  = fwd_ok && (rd_q == rm_addr_in) && (rm_addr_in != NO_FWD_ADDR);
      op_a   = fwd_a ? result_q : rn_data_in;
      rm_val = fwd_b ? result_q : rm_data_in;
   end
`else
   logic unused_addr;
   assign unused_addr = ^{rn_addr_in, rm_addr_in};

   always_comb begin
      op_a   = rn_data_in;
      rm_val = rm_data_in;
   end
`endif

   assign op_b = alu_src_select_in ? imm_in : rm_val;

   ex_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .a_in       (op_a),
      .b_in       (op_b),
      .op_in      (alu_op_e'(alu_control_in)),
      .c_in       (flags_q[FLAG_C]),
      .v_in       (flags_q[FLAG_V]),
      .result_out (alu_result),
      .nzcv_out   (alu_nzcv)
   );

   always_comb begin
      valid_d  = valid_q;
      rwe_d    = rwe_q;
      mwe_d    = mwe_q;
      mtr_d    = mtr_q;
      result_d = result_q;
      store_d  = store_q;
      rd_d     = rd_q;
      flags_d  = flags_q;
      cnt_d    = cnt_q;

      if (flush_in) begin
         valid_d  = 1'b0;
         rwe_d    = 1'b0;
         mwe_d    = 1'b0;
         mtr_d    = 1'b0;
         result_d = '0;
         store_d  = '0;
         rd_d     = '0;
      end else if (stall_in) begin
         if (valid_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end else begin
         // Controls are gated by valid_in so a bubble can never write
         valid_d  = valid_in;
         rwe_d    = reg_write_enable_in && valid_in;
         mwe_d    = mem_write_enable_in && valid_in;
         mtr_d    = mem_to_reg_select_in && valid_in;
         result_d = alu_result;
         store_d  = rm_val;
         rd_d     = rd_addr_in;
         if (valid_in && set_flags_in) begin
            flags_d = alu_nzcv;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         rwe_q    <= 1'b0;
         mwe_q    <= 1'b0;
         mtr_q    <= 1'b0;
         result_q <= '0;
         store_q  <= '0;
         rd_q     <= '0;
         flags_q  <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         rwe_q    <= rwe_d;
         mwe_q    <= mwe_d;
         mtr_q    <= mtr_d;
         result_q <= result_d;
         store_q  <= store_d;
         rd_q     <= rd_d;
         flags_q  <= flags_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ready_out             = !stall_in || flush_in;
   assign valid_out             = valid_q;
   assign reg_write_enable_out  = rwe_q;
   assign mem_write_enable_out  = mwe_q;
   assign mem_to_reg_select_out = mtr_q;
   assign alu_result_out        = result_q;
   assign store_data_out        = store_q;
   assign rd_addr_out           = rd_q;
   assign flags_out             = flags_q;
   assign stall_count_out       = cnt_q;

endmodule
